spi_flash_selftest: RTL
=======================

Name: spi_flash_selftest

Overview:
- Parametrised self-test sequencer for the SPI flash collection block; successor to the single-pattern FIFO auto-filler.
- Per page: fills the collection's direct FIFO with a selectable pattern, issues a page write, issues a read-back, drains the FIFO and compares against the regenerated pattern.
- Loops over NUM_PAGES-style runtime page count; reports error count, first failing address, pass/done.
- Sits between the VIO (control/status probes) and the collection instance, replacing direct VIO drive of read/write/address/byte counts.

Parameters:
- FIFO_DEPTH, 2000, collection FIFO depth; upper bound on bytes per page.
- ADDR_W, 24, flash address width.
- CNT_W, 16, width of byte-count ports and counters.
- PAGE_STRIDE, 256, address increment between consecutive pages.
- TIMEOUT, 1000000, max cycles in any wait state before abort.

Ports:
- clk  in  1  system clock (clk_wiz output).
- rst  in  1  synchronous active-high reset.
- start  in  1  level from VIO; rising edge launches a run when idle.
- pattern_mode  in  2  0 incrementing, 1 constant, 2 LFSR, 3 address-low-byte.
- seed  in  8  pattern seed.
- base_addr  in  ADDR_W  first page address.
- num_bytes  in  CNT_W  bytes per page, legal 1..FIFO_DEPTH.
- num_pages  in  8  pages per run, legal 1..255.
- flash_busy  in  1  high while collection executes a read or write.
- read  out  1  one-cycle read request to collection.
- write  out  1  one-cycle write request to collection.
- address  out  ADDR_W  current page address.
- numByte_write  out  32  zero-extended num_bytes.
- numByte_read  out  CNT_W  equal to num_bytes.
- direct_fifo  out  1  high while sequencer owns the FIFO port (FILL, DRAIN).
- direct_buf_in  out  8  fill data.
- direct_wr_en_buf  out  1  fill write strobe.
- direct_buf_out  in  8  FIFO read data, valid one cycle after direct_rd_en_buf.
- direct_rd_en_buf  out  1  drain read strobe.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start edge.
- pass  out  1  valid with done: err_count==0 and no timeout.
- timeout_err  out  1  sticky abort flag for the run.
- err_count  out  CNT_W  mismatching bytes, saturates at all-ones.
- first_err_addr  out  ADDR_W  flash address of first mismatch.

Behaviour:
- Reset: all outputs 0, state IDLE, address 0, counters 0. Reset mid-run aborts immediately; no request pulses after reset.
- start edge detected by registered previous value; ignored outside IDLE/DONE. Edge in DONE clears done/pass/err_count/first_err_addr/timeout_err and starts a new run.
- Inputs pattern_mode, seed, base_addr, num_bytes, num_pages sampled at start edge; later changes ignored until next run. num_bytes clamped to 1..FIFO_DEPTH, num_pages 0 treated as 1.
- States: IDLE -> FILL -> WR_REQ -> WR_WAIT_HI -> WR_WAIT_LO -> RD_REQ -> RD_WAIT_HI -> RD_WAIT_LO -> DRAIN -> NEXT -> (FILL | DONE).
- FILL: direct_fifo=1, direct_wr_en_buf=1 for exactly num_bytes consecutive cycles, byte i = pattern(i).
- WR_REQ/RD_REQ: write/read high exactly one cycle, address stable from FILL through DRAIN.
- WAIT_HI waits for flash_busy=1, WAIT_LO for flash_busy=0; flash_busy already high in the request cycle counts. Any wait exceeding TIMEOUT cycles -> timeout_err=1, DONE, pass=0.
- DRAIN: direct_rd_en_buf high num_bytes cycles; compare direct_buf_out one cycle after each strobe against pattern(i); on mismatch err_count++ (saturating), first mismatch latches address+i (mod 2^ADDR_W).
- NEXT: page++; address += PAGE_STRIDE, wraps mod 2^ADDR_W; to DONE after num_pages pages.
- Patterns (i restarts at 0 each page, p = page index): mode0 (seed+i) mod 256; mode1 seed; mode2 8-bit Fibonacci LFSR, taps 8,6,5,4, shifted left per byte, initial state seed^p, state 0 replaced by 0x01, byte i = state after i shifts; mode3 (address+i)[7:0].
- Generator duplicated or rewound so FILL and DRAIN sequences are identical.
- DONE: busy=0, done=1, pass=(err_count==0 && !timeout_err).

Test Plan:
- Mode0, seed 0x10, num_bytes 4, num_pages 1, model echoes -> FIFO writes 10,11,12,13; one write and one read pulse; done=1, pass=1, err_count 0.
- Mode2, seed 0x00, num_bytes 3, two pages, base 0x0000F0 -> page0 seeded 0x01, page1 seeded 0x01^0x01=0x00->0x01; addresses 0x0000F0, 0x0001F0.
- Model corrupts byte 2 of page 1 (base 0x000100, stride 256) -> err_count 1, first_err_addr 0x000202, pass=0.
- flash_busy never rises after write, TIMEOUT 50 -> timeout_err=1, done at 51 wait cycles, pass=0.
- base_addr 0xFFFF00, two pages -> second address 0x000000 (wrap).
- Reset asserted during DRAIN -> next cycle all outputs 0, state IDLE; new start edge runs cleanly.

Source files
------------

// File: rtl/spi_flash_selftest_if.sv
// Sequencer <-> SPI flash collection port bundle.
// Master side is the self-test sequencer, slave side the collection.
interface spi_flash_selftest_if #(
  parameter int ADDR_W = 24,
  parameter int CNT_W  = 16
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [31:0]       numByte_write;
  logic [CNT_W-1:0]  numByte_read;
  logic              flash_busy;
  logic              direct_fifo;
  logic [7:0]        direct_buf_in;
  logic              direct_wr_en_buf;
  logic [7:0]        direct_buf_out;
  logic              direct_rd_en_buf;

  modport master (
    output read, write, address,
    output numByte_write, numByte_read,
    output direct_fifo, direct_buf_in,
    output direct_wr_en_buf, direct_rd_en_buf,
    input  flash_busy, direct_buf_out
  );

  modport slave (
    input  read, write, address,
    input  numByte_write, numByte_read,
    input  direct_fifo, direct_buf_in,
    input  direct_wr_en_buf, direct_rd_en_buf,
    output flash_busy, direct_buf_out
  );
endinterface

// File: rtl/spi_flash_selftest.sv
// SPI flash self-test: per page fill FIFO, write, read back,
// drain and compare against the regenerated pattern.
module spi_flash_selftest #(
  parameter int FIFO_DEPTH  = 2000,
  parameter int ADDR_W      = 24,
  parameter int CNT_W       = 16,
  parameter int PAGE_STRIDE = 256,
  parameter int TIMEOUT     = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  spi_flash_selftest_if.master fl,
  input  logic              start,
  input  logic [1:0]        pattern_mode,
  input  logic [7:0]        seed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_bytes,
  input  logic [7:0]        num_pages,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [3:0] {
    IDLE, FILL, WR_REQ, WR_WAIT_HI, WR_WAIT_LO,
    RD_REQ, RD_WAIT_HI, RD_WAIT_LO, DRAIN, NEXT, DONE
  } state_t;

  state_t            state_q, state_n;
  logic              start_q;
  logic [1:0]        mode_q;
  logic [7:0]        seed_q;
  logic [CNT_W-1:0]  nbytes_q;
  logic [7:0]        npages_q;
  logic [7:0]        page_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        lfsr_q;
  logic [31:0]       tcnt_q;
  logic              cmp_v;
  logic [7:0]        cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;

  logic              start_edge, last, tmo;
  logic [7:0]        lfsr_init, lfsr_cur, lfsr_step, pat;
  logic [CNT_W-1:0]  nbytes_clamp;
  logic              fill_en, drain_en, load_run, page_adv;
  logic              tmo_hit, wait_st, wr_c, rd_c;

  assign start_edge = start & ~start_q;
  assign last       = (cnt_q == nbytes_q - 1'b1);
  assign tmo        = (tcnt_q >= 32'(TIMEOUT));

  always_comb begin
    nbytes_clamp = num_bytes;
    if (num_bytes == '0)
      nbytes_clamp = 1;
    else if (num_bytes > CNT_W'(FIFO_DEPTH))
      nbytes_clamp = CNT_W'(FIFO_DEPTH);
  end

  // Index 0 reseeds the LFSR, so FILL and DRAIN replay the same bytes.
  always_comb begin
    lfsr_init = seed_q ^ page_q;
    if (lfsr_init == 8'h00)
      lfsr_init = 8'h01;
    lfsr_cur  = (cnt_q == '0) ? lfsr_init : lfsr_q;
    lfsr_step = {lfsr_cur[6:0],
                 lfsr_cur[7] ^ lfsr_cur[5] ^ lfsr_cur[4] ^ lfsr_cur[3]};
  end

  always_comb begin
    pat = seed_q;
    unique case (mode_q)
      2'd0: pat = seed_q + cnt_q[7:0];
      2'd1: pat = seed_q;
      2'd2: pat = lfsr_cur;
      2'd3: pat = addr_q[7:0] + cnt_q[7:0];
    endcase
  end

  always_comb begin
    state_n  = state_q;
    fill_en  = 1'b0;
    drain_en = 1'b0;
    load_run = 1'b0;
    page_adv = 1'b0;
    tmo_hit  = 1'b0;
    wait_st  = 1'b0;
    wr_c     = 1'b0;
    rd_c     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          load_run = 1'b1;
          state_n  = FILL;
        end
      end
      FILL: begin
        fill_en = 1'b1;
        if (last) state_n = WR_REQ;
      end
      WR_REQ: begin
        wr_c    = 1'b1;
        state_n = fl.flash_busy ? WR_WAIT_LO : WR_WAIT_HI;
      end
      WR_WAIT_HI: begin
        wait_st = 1'b1;
        if (fl.flash_busy) state_n = WR_WAIT_LO;
        else if (tmo) begin
          tmo_hit = 1'b1;
          state_n = DONE;
        end
      end
      WR_WAIT_LO: begin
        wait_st = 1'b1;
        if (!fl.flash_busy) state_n = RD_REQ;
        else if (tmo) begin
          tmo_hit = 1'b1;
          state_n = DONE;
        end
      end
      RD_REQ: begin
        rd_c    = 1'b1;
        state_n = fl.flash_busy ? RD_WAIT_LO : RD_WAIT_HI;
      end
      RD_WAIT_HI: begin
        wait_st = 1'b1;
        if (fl.flash_busy) state_n = RD_WAIT_LO;
        else if (tmo) begin
          tmo_hit = 1'b1;
          state_n = DONE;
        end
      end
      RD_WAIT_LO: begin
        wait_st = 1'b1;
        if (!fl.flash_busy) state_n = DRAIN;
        else if (tmo) begin
          tmo_hit = 1'b1;
          state_n = DONE;
        end
      end
      DRAIN: begin
        drain_en = 1'b1;
        if (last) state_n = NEXT;
      end
      NEXT: begin
        if (page_q + 8'd1 == npages_q) state_n = DONE;
        else begin
          page_adv = 1'b1;
          state_n  = FILL;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      mode_q         <= '0;
      seed_q         <= '0;
      nbytes_q       <= '0;
      npages_q       <= '0;
      page_q         <= '0;
      addr_q         <= '0;
      cnt_q          <= '0;
      lfsr_q         <= '0;
      tcnt_q         <= '0;
      cmp_v          <= 1'b0;
      cmp_exp        <= '0;
      cmp_addr       <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state_q  <= state_n;
      start_q  <= start;
      tcnt_q   <= (wait_st && state_n == state_q) ? tcnt_q + 1 : '0;
      cmp_v    <= drain_en;
      cmp_exp  <= pat;
      cmp_addr <= addr_q + ADDR_W'(cnt_q);
      if (fill_en || drain_en) begin
        cnt_q  <= last ? '0 : cnt_q + 1'b1;
        lfsr_q <= lfsr_step;
      end
      if (page_adv) begin
        page_q <= page_q + 8'd1;
        addr_q <= addr_q + ADDR_W'(PAGE_STRIDE);
      end
      if (tmo_hit)
        timeout_err <= 1'b1;
      // Read data lands one cycle after its strobe.
      if (cmp_v && fl.direct_buf_out != cmp_exp) begin
        if (err_count != '1)
          err_count <= err_count + 1'b1;
        if (err_count == '0)
          first_err_addr <= cmp_addr;
      end
      if (load_run) begin
        mode_q         <= pattern_mode;
        seed_q         <= seed;
        nbytes_q       <= nbytes_clamp;
        npages_q       <= (num_pages == 8'd0) ? 8'd1 : num_pages;
        addr_q         <= base_addr;
        page_q         <= '0;
        cnt_q          <= '0;
        cmp_v          <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
        timeout_err    <= 1'b0;
      end
    end
  end

  assign fl.write            = wr_c;
  assign fl.read             = rd_c;
  assign fl.address          = addr_q;
  assign fl.numByte_write    = 32'(nbytes_q);
  assign fl.numByte_read     = nbytes_q;
  assign fl.direct_fifo      = fill_en | drain_en;
  assign fl.direct_buf_in    = fill_en ? pat : 8'h00;
  assign fl.direct_wr_en_buf = fill_en;
  assign fl.direct_rd_en_buf = drain_en;

  assign busy = (state_q != IDLE) && (state_q != DONE);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == '0) && !timeout_err;

endmodule
